// File: rtl/median_stream.sv
// Streaming 3x3 median filter over PIXELS_PER_WORD-pixel row words with
// valid/ready handshakes, edge replication and an end-of-line flush word.
// Optional feature macro: MEDIAN_BYPASS_EN (adds a per-word bypass input).
module median_stream #(
   parameter int unsigned PIXEL_WIDTH     = 8,
   parameter int unsigned PIXELS_PER_WORD = 4,
   parameter int unsigned LINE_WORDS      = 160,
   parameter int unsigned ADDR_WIDTH      = 10
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] row0,
   input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] row1,
   input  logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] row2,
`ifdef MEDIAN_BYPASS_EN
   input  logic                                   bypass,
`endif
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] out_data,
   output logic [ADDR_WIDTH-1:0]                  out_addr,
   output logic                                   out_eol
);

   localparam int unsigned WORD_W = PIXEL_WIDTH * PIXELS_PER_WORD;
   localparam int unsigned COL_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int unsigned NCX    = 19;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   // Exchange pairs of a 19-step median-of-9 network; min lands on the A index.
   localparam int unsigned CX_A [NCX] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
   localparam int unsigned CX_B [NCX] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

   typedef logic [PIXEL_WIDTH-1:0] pix_t;

   logic [0:0]        state;
   logic [0:0]        state_next;
   logic [COL_W-1:0]  col;
   logic [WORD_W-1:0] cur [3];
   pix_t              left [3];
   logic [WORD_W-1:0] in_word [3];
   pix_t              win [9];
   logic [WORD_W-1:0] med_word;
   logic [WORD_W-1:0] result_word;
   logic              out_free;
   logic              accept;
   logic              last_col;
   logic              flush_load;

   // Pixel i of a word; pixel 0 is the leftmost, held in the MSB slice.
   function automatic pix_t px(input logic [WORD_W-1:0] w, input int unsigned i);
      return w[(PIXELS_PER_WORD-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH];
   endfunction

   // Compare-exchange network returning the 5th smallest of nine values.
   function automatic pix_t median9(input pix_t v_in [9]);
      pix_t v [9];
      pix_t t;
      v = v_in;
      for (int unsigned k = 0; k < NCX; k++) begin
         if (v[CX_A[k]] > v[CX_B[k]]) begin
            t          = v[CX_A[k]];
            v[CX_A[k]] = v[CX_B[k]];
            v[CX_B[k]] = t;
         end
      end
      return v[4];
   endfunction

   assign in_word[0] = row0;
   assign in_word[1] = row1;
   assign in_word[2] = row2;

   assign out_free   = !out_valid || out_ready;
   assign in_ready   = (state == ST_RUN) && out_free;
   assign accept     = in_valid && in_ready;
   assign last_col   = (col == COL_W'(LINE_WORDS - 1));
   assign flush_load = (state == ST_FLUSH) && out_free;

   // Median of every pixel of the current word; right neighbour of the last
   // pixel is the incoming word in RUN and the pixel itself in FLUSH.
   always_comb begin
      med_word = '0;
      win      = '{default: '0};
      for (int unsigned i = 0; i < PIXELS_PER_WORD; i++) begin
         for (int unsigned r = 0; r < 3; r++) begin
            win[r*3+0] = (i == 0) ? left[r] : px(cur[r], (i == 0) ? 0 : i - 1);
            win[r*3+1] = px(cur[r], i);
            if (i == PIXELS_PER_WORD - 1)
               win[r*3+2] = (state == ST_FLUSH) ? px(cur[r], i) : px(in_word[r], 0);
            else
               win[r*3+2] = px(cur[r], (i == PIXELS_PER_WORD - 1) ? i : i + 1);
         end
         med_word[(PIXELS_PER_WORD-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH] = median9(win);
      end
   end

`ifdef MEDIAN_BYPASS_EN
   logic cur_bypass;

   // Bypass flag travels with the word held in the window.
   always_ff @(posedge clk) begin
      if (rst)
         cur_bypass <= 1'b0;
      else if (accept)
         cur_bypass <= bypass;
   end

   assign result_word = cur_bypass ? cur[1] : med_word;
`else
   assign result_word = med_word;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_RUN;
      else
         state <= state_next;
   end

   // Next state: enter FLUSH after the last word of a line, leave once it loads.
   always_comb begin
      state_next = state;
      if (state == ST_RUN) begin
         if (accept && last_col)
            state_next = ST_FLUSH;
      end else begin
         if (flush_load)
            state_next = ST_RUN;
      end
   end

   // Window shift, column counter and one-deep output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_eol   <= 1'b0;
         for (int unsigned r = 0; r < 3; r++) begin
            cur[r]  <= '0;
            left[r] <= '0;
         end
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_addr  <= out_addr + 1'b1;
         end
         if (accept) begin
            for (int unsigned r = 0; r < 3; r++)
               cur[r] <= in_word[r];
            if (col == '0) begin
               for (int unsigned r = 0; r < 3; r++)
                  left[r] <= px(in_word[r], 0);
               col <= COL_W'(1);
            end else begin
               out_valid <= 1'b1;
               out_data  <= result_word;
               out_eol   <= 1'b0;
               for (int unsigned r = 0; r < 3; r++)
                  left[r] <= px(cur[r], PIXELS_PER_WORD - 1);
               col <= last_col ? '0 : col + 1'b1;
            end
         end
         if (flush_load) begin
            out_valid <= 1'b1;
            out_data  <= result_word;
            out_eol   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_median_stream.sv
// Self-checking bench for median_stream: directed and random lines checked
// against a clamp-at-border, sort-based 3x3 median model.
module tb_median_stream;

   localparam int unsigned PW   = 8;
   localparam int unsigned PPW  = 4;
   localparam int unsigned LW   = 2;
   localparam int unsigned AW   = 2;
   localparam int unsigned WW   = PW * PPW;
   localparam int unsigned NPIX = LW * PPW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [WW-1:0] row0;
   logic [WW-1:0] row1;
   logic [WW-1:0] row2;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_eol;
`ifdef MEDIAN_BYPASS_EN
   logic          bypass;
`endif

   typedef struct packed {
      logic [WW-1:0] data;
      logic [AW-1:0] addr;
      logic          eol;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp;
   int          n_err;
   int          m_addr;
   int unsigned img [3][NPIX];
   bit          rnd_ready;
   bit          rnd_gap;
   bit          stall_arm;
   int          stall_cnt;

   median_stream #(
      .PIXEL_WIDTH(PW), .PIXELS_PER_WORD(PPW), .LINE_WORDS(LW), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .row0(row0), .row1(row1), .row2(row2),
`ifdef MEDIAN_BYPASS_EN
      .bypass(bypass),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .out_eol(out_eol)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: 5th smallest of the 3x3 neighbourhood, columns clamped at line ends.
   task automatic push_line_expect();
      int unsigned   vals [9];
      int unsigned   t;
      int            k;
      int            xx;
      logic [WW-1:0] data;
      exp_t          e;
      for (int w = 0; w < int'(LW); w++) begin
         data = '0;
         for (int j = 0; j < int'(PPW); j++) begin
            k = 0;
            for (int r = 0; r < 3; r++) begin
               for (int d = -1; d <= 1; d++) begin
                  xx = w * int'(PPW) + j + d;
                  if (xx < 0) xx = 0;
                  if (xx > int'(NPIX) - 1) xx = int'(NPIX) - 1;
                  vals[k] = img[r][xx];
                  k++;
               end
            end
            for (int a = 1; a < 9; a++)
               for (int b = a; b > 0 && vals[b-1] > vals[b]; b--) begin
                  t = vals[b]; vals[b] = vals[b-1]; vals[b-1] = t;
               end
            data[(int'(PPW)-1-j)*int'(PW) +: PW] = PW'(vals[4]);
         end
         e.data = data;
         e.addr = AW'(m_addr);
         e.eol  = (w == int'(LW) - 1);
         exp_q.push_back(e);
         m_addr = (m_addr + 1) % (1 << AW);
      end
   endtask

   function automatic logic [WW-1:0] word_of(input int r, input int w);
      logic [WW-1:0] v;
      v = '0;
      for (int j = 0; j < int'(PPW); j++)
         v[(int'(PPW)-1-j)*int'(PW) +: PW] = PW'(img[r][w*int'(PPW)+j]);
      return v;
   endfunction

   // Called in the posedge+1 phase; returns in the same phase after acceptance.
   task automatic send_word(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [WW-1:0] c);
      int n;
      row0 = a; row1 = b; row2 = c;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 300);
      if (!in_ready) check_eq("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_line();
      push_line_expect();
      for (int w = 0; w < int'(LW); w++) begin
         if (rnd_gap)
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send_word(word_of(0, w), word_of(1, w), word_of(2, w));
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic fill(input int unsigned v0, input int unsigned v1, input int unsigned v2);
      for (int x = 0; x < int'(NPIX); x++) begin
         img[0][x] = v0; img[1][x] = v1; img[2][x] = v2;
      end
   endtask

   task automatic fill_random();
      for (int r = 0; r < 3; r++)
         for (int x = 0; x < int'(NPIX); x++)
            img[r][x] = $urandom_range(0, 255);
   endtask

   // Downstream ready: always, random, or a forced 5-cycle stall on first output.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_arm && out_valid) begin
            stall_arm = 1'b0;
            stall_cnt = 5;
         end
         if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
         end else if (rnd_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Output monitor: every valid cycle must present the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 64'd1, 64'd0);
         end else begin
            check_eq("out_data", 64'(out_data), 64'(exp_q[0].data));
            check_eq("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
            check_eq("out_eol",  64'(out_eol),  64'(exp_q[0].eol));
            if (out_ready) void'(exp_q.pop_front());
         end
         if (!out_ready) check_eq("in_ready_stall", 64'(in_ready), 64'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0; m_addr = 0;
      rnd_ready = 1'b0; rnd_gap = 1'b0; stall_arm = 1'b0; stall_cnt = 0;
      rst = 1'b1; in_valid = 1'b0;
      row0 = '0; row1 = '0; row2 = '0;
`ifdef MEDIAN_BYPASS_EN
      bypass = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_data",  64'(out_data),  64'd0);
      check_eq("rst_out_addr",  64'(out_addr),  64'd0);
      check_eq("rst_out_eol",   64'(out_eol),   64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Uniform rows: centre row wins.
      fill(10, 20, 30);
      send_line();
      wait_drain();

      // Single spike in the centre row is removed.
      fill(50, 50, 50);
      img[1][1] = 255;
      send_line();
      wait_drain();

      // Left-edge replication keeps the dark first column.
      fill(100, 100, 100);
      for (int r = 0; r < 3; r++) img[r][0] = 0;
      send_line();
      wait_drain();

      // Five-cycle downstream stall on the first output.
      fill_random();
      stall_arm = 1'b1;
      send_line();
      wait_drain();

      // Random data, random gaps, random backpressure; addresses wrap.
      rnd_ready = 1'b1;
      rnd_gap   = 1'b1;
      for (int l = 0; l < 9; l++) begin
         fill_random();
         send_line();
      end
      wait_drain();
      rnd_ready = 1'b0;
      rnd_gap   = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // Reset after a line's first word: partial window discarded.
      fill_random();
      send_word(word_of(0, 0), word_of(1, 0), word_of(2, 0));
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_out_addr",  64'(out_addr),  64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      m_addr = 0;
      @(posedge clk); #1;
      fill_random();
      send_line();
      wait_drain();

      repeat (5) @(posedge clk);
      #1;
      check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("final_idle", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/median_stream.md
Name: median_stream

Overview:
- Streaming 3x3 median filter, the parametrised successor of the fixed 4-pixel median block.
- Each cycle it accepts one column-aligned word from each of three image rows (upper, centre, lower). Each word carries PIXELS_PER_WORD pixels.
- It emits one word of PIXELS_PER_WORD median pixels for the centre row, with a write address.
- It adds valid/ready handshakes, a per-line word counter, edge-pixel replication at line borders and an end-of-line flush. It sits between the line-buffer read side and the output memory.

Parameters:
PIXEL_WIDTH, 8, bits per pixel.
PIXELS_PER_WORD, 4, pixels per row word; must be >=2.
LINE_WORDS, 160, words per image line; must be >=2.
ADDR_WIDTH, 10, output address width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  row words valid.
in_ready  out  1  block accepts words this cycle.
row0  in  PIXEL_WIDTH*PIXELS_PER_WORD  upper-row word.
row1  in  PIXEL_WIDTH*PIXELS_PER_WORD  centre-row word.
row2  in  PIXEL_WIDTH*PIXELS_PER_WORD  lower-row word.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts output.
out_data  out  PIXEL_WIDTH*PIXELS_PER_WORD  median pixels.
out_addr  out  ADDR_WIDTH  write address of out_data.
out_eol  out  1  out_data is the last word of a line.

Behaviour:
- Reset: out_valid=0, out_data=0, out_addr=0, out_eol=0, column counter=0, state=RUN. in_ready=1 after the reset cycle. Reset mid-line discards the partial window and any pending output.
- Pixel order: pixel 0 is the most-significant PIXEL_WIDTH slice and the leftmost pixel; pixel PIXELS_PER_WORD-1 is the LSB slice.
- Accept: a word is accepted when in_valid && in_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Output register: one deep. It holds until out_valid && out_ready. It loads only when empty or draining the same cycle.
- Window state, all registered:
  - the current word (3 rows);
  - the previous word's rightmost column (3 pixels);
  - column counter 0..LINE_WORDS-1.
- Accept with col==0: current<=incoming; left column <= incoming pixel 0 (replicated); no output; col<=1.
- Accept with col>0:
  - out_data <= median of the current word. Window columns are: left column, current pixels, incoming pixel 0.
  - left column <= current rightmost; current<=incoming; col++.
  - out_eol=0.
- Accept with col==LINE_WORDS-1: after the update above, state<=FLUSH and col<=0.
- FLUSH:
  - in_ready=0.
  - When the output register is free, out_data <= median of the current word, with the rightmost pixel's right column replicated from itself. out_eol=1.
  - state<=RUN.
- Per-pixel median: the 5th smallest of the 9 unsigned pixels of the 3x3 window. Use a combinational compare-exchange network feeding the output register. No arithmetic widening.
- Latency: word k's result is valid the cycle after word k+1 is accepted. For the last word of a line, the result is valid the cycle after FLUSH loads.
- out_addr: increments by 1 on each output handshake and wraps at 2^ADDR_WIDTH. It is never reset by end of line.
- Backpressure: out_valid, out_data, out_addr and out_eol are stable while out_valid && !out_ready.
- Throughput: one word per cycle in steady state, plus one bubble per line (the FLUSH cycle).

Optional Feature:
- Macro MEDIAN_BYPASS_EN.
- Defined: adds input port bypass (1 bit), sampled with each accepted word and carried with it. A word flagged bypass outputs its centre-row (row1) pixels unmodified, with identical latency, handshake, out_addr and out_eol behaviour.
- Undefined: the port is absent and all words are median-filtered.

Test Plan:
- Test parameters: LINE_WORDS=2, PIXELS_PER_WORD=4, PIXEL_WIDTH=8.
- Uniform rows: row0=all 10, row1=all 20, row2=all 30, two words -> two outputs of {20,20,20,20}; out_addr 0 then 1; out_eol 0 then 1.
- Spike removal: all pixels 50 except row1 word0 pixel1=255 -> both outputs {50,50,50,50}.
- Left edge replication: every row word0={0,100,100,100}, word1=all 100 -> word0 output {0,100,100,100}; word1 output {100,100,100,100}.
- Backpressure: out_ready=0 for 5 cycles after the first output -> out_data/out_addr held; in_ready=0; no word lost; after release, the sequence is identical to the unstalled run.
- Wrap and reset:
  - ADDR_WIDTH=2, 3 lines -> addresses 0,1,2,3,0,1.
  - Assert rst after a line's first word -> out_valid=0, out_addr=0, and the next accepted word is treated as col 0.
